// File: rtl/uart_txfifo_pkg.sv
// Shared definitions for the uart transmit buffer: register map, status bits, drain states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_txfifo_pkg;

  // Register addresses, shared by the CPU window and the uart register port
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_LEVEL  = 2'd2;

  // Bit positions inside a status byte
  localparam int STAT_BUSY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF  = 2;

  // Drain sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POLL  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } drain_state_e;

  // Pack the CPU-visible status flags into one byte
  function automatic logic [7:0] status_byte(input logic ovf, input logic full, input logic busy);
    logic [7:0] s;
    s            = 8'h00;
    s[STAT_BUSY] = busy;
    s[STAT_FULL] = full;
    s[STAT_OVF]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_txfifo_sync_fifo.sv
// Generic single-clock FIFO with a combinational head output and an occupancy count.
// Latency: a push is visible at dout/count on the cycle after the push edge.
// Backpressure: push while full is dropped (even with a pop that cycle); pop while empty is ignored.
module sync_fifo
  import uart_txfifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged on the pre-edge count, so a simultaneous pop never rescues a push
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_txfifo.sv
// CPU-facing transmit buffer that drains bytes into the uart after polling its busy bit.
// Latency: CPU reads answer one cycle after rd_en; an idle path delivers a pushed byte to the uart 3 cycles after the push edge.
// Backpressure: CPU is never stalled; pushes into a full buffer are dropped and flagged in a sticky ovf bit.
module uart_txfifo
  import uart_txfifo_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] addr,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [1:0] u_addr,
  output logic       u_rd_en,
  input  logic [7:0] u_rd_data,
  input  logic       u_rd_valid,
  output logic       u_wr_en,
  output logic [7:0] u_wr_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  drain_state_e  state;
  logic [TW-1:0] timer;
  logic          ovf;
  logic          push;
  logic          pop;
  logic          busy;
  logic          uart_busy;
  logic          unused_status;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    level8;

  assign push          = wr_en && (addr == REG_DATA);
  assign uart_busy     = u_rd_data[STAT_BUSY];
  // Only the busy flag of the uart status matters to the drain sequencer
  assign unused_status = ^u_rd_data[7:1];
  // The pop coincides with the hand-off edge so the byte leaves as u_wr_en rises
  assign pop           = (state == ST_WAIT) && u_rd_valid && !uart_busy;
  assign busy          = !fifo_empty || (state != ST_IDLE);
  // A full 256-entry buffer reads back as 0 because only 8 bits are visible
  assign level8        = 8'(fifo_count);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // CPU register window: one-cycle read response and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= 8'h00;
      if (rd_en) begin
        case (addr)
          REG_STATUS: rd_data <= status_byte(ovf, fifo_full, busy);
          REG_LEVEL:  rd_data <= level8;
          default:    rd_data <= 8'h00;
        endcase
      end
      // A new overflow wins over a same-cycle clearing read so it is never lost
      if (push && fifo_full) begin
        ovf <= 1'b1;
      end else if (rd_en && (addr == REG_STATUS)) begin
        ovf <= 1'b0;
      end
    end
  end

  // Drain sequencer: poll uart status, retry on busy or timeout, then hand over the head byte
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      timer     <= '0;
      u_rd_en   <= 1'b0;
      u_wr_en   <= 1'b0;
      u_addr    <= REG_DATA;
      u_wr_data <= 8'h00;
    end else begin
      u_rd_en <= 1'b0;
      u_wr_en <= 1'b0;
      u_addr  <= REG_DATA;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state   <= ST_POLL;
            u_rd_en <= 1'b1;
            u_addr  <= REG_STATUS;
          end
        end
        ST_POLL: begin
          state <= ST_WAIT;
          timer <= '0;
        end
        ST_WAIT: begin
          if (u_rd_valid) begin
            if (uart_busy) begin
              state   <= ST_POLL;
              u_rd_en <= 1'b1;
              u_addr  <= REG_STATUS;
            end else begin
              state     <= ST_WRITE;
              u_wr_en   <= 1'b1;
              u_addr    <= REG_DATA;
              u_wr_data <= fifo_dout;
            end
          end else if (timer == TMO_LAST) begin
            state   <= ST_POLL;
            u_rd_en <= 1'b1;
            u_addr  <= REG_STATUS;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
